// File: rtl/aes_ctr_packer.sv
// aes_ctr_packer: packs 32-bit plaintext words into 128-bit blocks, each tagged
// with its AES-CTR counter block {nonce, ctr}.
module aes_ctr_packer #(
  parameter int CTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [127-CTR_W:0] nonce,
  input  logic [CTR_W-1:0]   ctr_init,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_word,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_block,
  output logic [127:0]       out_ctr,
  output logic               out_last,
  output logic [2:0]         out_nwords,
  output logic               busy,
  output logic               done,
  output logic               ctr_wrap
);
  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
  state_t r_state, w_next;
  logic [127-CTR_W:0] r_nonce;
  logic [CTR_W-1:0] r_ctr;
  logic [1:0] r_idx;
  logic [127:0] r_block;
  logic [2:0] r_nwords;
  logic r_last, r_wrap;
  logic w_acc, w_fin, w_hand;
  logic [6:0] w_base;
  always_comb begin
    w_acc = r_state == FILL && in_valid;
    w_fin = w_acc && (in_last || r_idx == 2'd3);
    w_hand = r_state == EMIT && out_ready;
    w_base = {~r_idx, 5'd0};
    w_next = r_state;
    if (r_state == IDLE && start) w_next = FILL;
    if (w_fin) w_next = EMIT;
    if (w_hand) w_next = r_last ? IDLE : FILL;
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nonce <= '0;
      r_ctr <= '0;
      r_idx <= '0;
      r_block <= '0;
      r_nwords <= '0;
      r_last <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_nonce <= nonce;
        r_ctr <= ctr_init;
        r_idx <= '0;
        r_block <= '0;
        r_wrap <= 1'b0;
      end
      if (w_acc) begin
        r_block[w_base +: 32] <= in_word;
        r_idx <= r_idx + 2'd1;
      end
      if (w_fin) begin
        r_nwords <= {1'b0, r_idx} + 3'd1;
        r_last <= in_last;
      end
      // clearing on handoff keeps unfilled slots of the next partial block zero
      if (w_hand) begin
        r_ctr <= r_ctr + {{(CTR_W-1){1'b0}}, 1'b1};
        r_idx <= '0;
        r_block <= '0;
        if (&r_ctr) r_wrap <= 1'b1;
      end
    end
  end
  assign in_ready = r_state == FILL;
  assign out_valid = r_state == EMIT;
  assign busy = r_state != IDLE;
  assign done = w_hand && r_last;
  assign out_block = r_block;
  assign out_ctr = {r_nonce, r_ctr};
  assign out_last = r_last;
  assign out_nwords = r_nwords;
  assign ctr_wrap = r_wrap;
endmodule

// File: tb/tb_aes_ctr_packer.sv
// tb_aes_ctr_packer: table-driven messages with a block scoreboard, plus stall,
// reset and restart-ignore sequences.
module tb_aes_ctr_packer;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_last, out_ready;
  logic [95:0] nonce;
  logic [31:0] ctr_init, in_word;
  logic in_ready, out_valid, out_last, busy, done, ctr_wrap;
  logic [127:0] out_block, out_ctr;
  logic [2:0] out_nwords;
  typedef struct { logic [95:0] nonce; logic [31:0] ctr; int n; int nb; logic wrap; } vec_t;
  typedef struct { logic [127:0] blk; logic [127:0] ctr; logic [2:0] nw; logic last; } exp_t;
  exp_t q[$];
  vec_t vt[8];
  int n_tests = 0, n_fail = 0, n_hand = 0, rdy_mode = 0;

  aes_ctr_packer dut (
    .clk(clk), .rst(rst), .start(start), .nonce(nonce), .ctr_init(ctr_init),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .out_ctr(out_ctr),
    .out_last(out_last), .out_nwords(out_nwords), .busy(busy), .done(done), .ctr_wrap(ctr_wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  function automatic void chk(string nm, logic [127:0] a, logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endfunction

  function automatic logic [31:0] wf(int s, int k);
    return 32'(s * 32'h01000193) ^ 32'((k + 1) * 32'h9E3779B9);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      n_hand++;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_block got ctr %h want none", out_ctr);
      end else begin
        e = q.pop_front();
        chk("block", out_block, e.blk);
        chk("ctr", out_ctr, e.ctr);
        chk("nwords", 128'(out_nwords), 128'(e.nw));
        chk("last", 128'(out_last), 128'(e.last));
        chk("done", 128'(done), 128'(e.last));
      end
    end
  end

  task automatic push_exp(input logic [95:0] nc, input logic [31:0] c, input int n, input int s);
    int nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      exp_t e;
      e.blk = '0;
      for (int k = 0; k < 4; k++)
        if (4 * b + k < n) e.blk[127 - 32 * k -: 32] = wf(s, 4 * b + k);
      e.ctr = {nc, c + 32'(b)};
      e.nw = 3'((n - 4 * b) > 4 ? 4 : (n - 4 * b));
      e.last = b == nb - 1;
      q.push_back(e);
    end
  endtask

  task automatic start_msg(input logic [95:0] nc, input logic [31:0] c);
    start = 1'b1;
    nonce = nc;
    ctr_init = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    bit got = 0;
    repeat ($urandom_range(0, 1)) begin
      in_valid = 1'b0;
      in_last = 1'b1;
      in_word = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_word = w;
    in_last = l;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!got) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic feed(input int s, input int lo, input int hi, input int n);
    for (int k = lo; k <= hi; k++) send_word(wf(s, k), k == n - 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) break;
    end
    chk("idle", 128'(busy), 0);
    chk("queue_empty", 128'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int h0;
    vt[0] = '{96'hA1A2A3A4_B1B2B3B4_C1C2C3C4, 32'h5, 4, 1, 1'b0};
    vt[1] = '{96'h111111112222222233333333, 32'h5, 6, 2, 1'b0};
    vt[2] = '{96'hDEADBEEF00C0FFEE12345678, 32'hFFFFFFFF, 5, 2, 1'b1};
    vt[3] = '{96'h0, 32'h0, 1, 1, 1'b0};
    vt[4] = '{96'hFFFFFFFFFFFFFFFFFFFFFFFF, 32'hA, 8, 2, 1'b0};
    vt[5] = '{96'h0123456789ABCDEF01234567, 32'hFFFFFFFE, 12, 3, 1'b1};
    vt[6] = '{96'h5A5A5A5A5A5A5A5A5A5A5A5A, 32'h7, 3, 1, 1'b0};
    vt[7] = '{96'hCAFEBABECAFEBABECAFEBABE, 32'hFFFFFFFD, 8, 2, 1'b0};
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    nonce = '0; ctr_init = '0; in_word = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", 128'({in_ready, out_valid, out_last, busy, done, ctr_wrap, out_nwords}), 0);
    chk("reset_block", out_block, 0);
    chk("reset_ctr", out_ctr, 0);
    @(posedge clk); #1;
    for (int vi = 0; vi < 8; vi++) begin
      rdy_mode = vi % 2;
      h0 = n_hand;
      push_exp(vt[vi].nonce, vt[vi].ctr, vt[vi].n, vi + 1);
      start_msg(vt[vi].nonce, vt[vi].ctr);
      feed(vi + 1, 0, vt[vi].n - 1, vt[vi].n);
      wait_idle();
      chk("nblocks", 128'(n_hand - h0), 128'(vt[vi].nb));
      chk("wrap", 128'(ctr_wrap), 128'(vt[vi].wrap));
    end
    // downstream stall: block must hold while a pending word waits
    rdy_mode = 2;
    @(posedge clk); #1;
    h0 = n_hand;
    push_exp(96'hFEEDFACE0000000012345678, 32'd20, 8, 20);
    start_msg(96'hFEEDFACE0000000012345678, 32'd20);
    feed(20, 0, 3, 8);
    in_valid = 1'b1;
    in_word = wf(20, 4);
    in_last = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_hold", {out_valid, in_ready, out_nwords, out_last}, {1'b1, 1'b0, 3'd4, 1'b0});
      chk("stall_block", out_block, q[0].blk);
      chk("stall_ctr", out_ctr, q[0].ctr);
    end
    rdy_mode = 0;
    feed(20, 4, 7, 8);
    wait_idle();
    chk("stall_nblocks", 128'(n_hand - h0), 2);
    // start during FILL must not disturb the running message
    h0 = n_hand;
    push_exp(96'hAAAA0000BBBB0000CCCC0000, 32'd40, 6, 30);
    start_msg(96'hAAAA0000BBBB0000CCCC0000, 32'd40);
    feed(30, 0, 1, 6);
    start_msg(96'h123123123123123123123123, 32'd99);
    feed(30, 2, 5, 6);
    wait_idle();
    chk("restart_nblocks", 128'(n_hand - h0), 2);
    // reset mid-FILL discards the partial block
    h0 = n_hand;
    start_msg(96'h777777777777777777777777, 32'd3);
    feed(50, 0, 1, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_flags", 128'({in_ready, out_valid, out_last, busy, done, ctr_wrap, out_nwords}), 0);
    chk("rst_mid_block", out_block, 0);
    chk("rst_mid_ctr", out_ctr, 0);
    repeat (10) @(negedge clk);
    chk("rst_mid_noblock", 128'(n_hand - h0), 0);
    @(posedge clk); #1;
    h0 = n_hand;
    push_exp(vt[1].nonce, 32'd9, 6, 40);
    start_msg(vt[1].nonce, 32'd9);
    feed(40, 0, 5, 6);
    wait_idle();
    chk("post_rst_nblocks", 128'(n_hand - h0), 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
